mem_arbiter: RTL and testbench

- Shares the single byte-serial RAM port between three requesters: instruction fetch (IF), load (LD) and store (ST).
- Sequences multi-byte reads and writes, including the RAM's 1-cycle read latency.
- Stalls I/O stores while the I/O buffer is full.
- Supports flush abort of in-flight reads.
- Sits between the fetch/LSB units and the RAM pins.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_pick.sv | 28 ++
 rtl/mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the RAM port arbiter.
// Optional starvation guard is enabled with MEM_ARB_STARVE_GUARD_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_IF = 2'd0,
        OWN_LD = 2'd1,
        OWN_ST = 2'd2
    } owner_t;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    localparam logic [1:0] IO_ADDR_HI_DEF   = 2'b11;
    localparam logic [2:0] STARVE_LIMIT_DEF = 3'd4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker: ST > LD > IF unless IF is starved.
// Flush suppresses read grants; stores are unaffected.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       if_req,
    input  logic       ld_req,
    input  logic       st_req,
    input  logic       st_ok,
    input  logic       flush,
    input  logic       starve_hit,
    output logic [2:0] grant
);

    always_comb begin
        grant = '0;
        if (starve_hit && if_req && !flush) begin
            grant[OWN_IF] = 1'b1;
        end else if (st_req && st_ok) begin
            grant[OWN_ST] = 1'b1;
        end else if (ld_req && !flush) begin
            grant[OWN_LD] = 1'b1;
        end else if (if_req && !flush) begin
            grant[OWN_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter for fetch, load and store.
// Define MEM_ARB_STARVE_GUARD_EN to force-grant a starved fetch.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [1:0] IO_ADDR_HI = IO_ADDR_HI_DEF
`ifdef MEM_ARB_STARVE_GUARD_EN
    ,
    parameter logic [2:0] STARVE_LIMIT = STARVE_LIMIT_DEF
`endif
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_len,
    output logic        ld_done,
    output logic [31:0] ld_data,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [2:0]  st_len,
    input  logic [31:0] st_data,
    output logic        st_done,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    state_t      state_q;
    state_t      state_d;
    owner_t      owner_q;
    logic [2:0]  cnt_q;
    logic [2:0]  len_q;
    logic [31:0] base_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf_q;
    logic [31:0] rmerge;
    logic [31:0] addr_cur;
    logic [1:0]  lane;
    logic [2:0]  grant;
    logic        st_ok;
    logic        starve_hit;

    assign st_ok    = !((st_addr[17:16] == IO_ADDR_HI) && io_buffer_full);
    assign addr_cur = base_q + {29'd0, cnt_q};
    assign lane     = cnt_q[1:0] - 2'd1;

    // RAM data lags the address by one cycle, so it lands in lane cnt-1.
    always_comb begin
        rmerge = rbuf_q;
        rmerge[{lane, 3'b000} +: 8] = mem_din;
    end

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .ld_req     (ld_req),
        .st_req     (st_req),
        .st_ok      (st_ok),
        .flush      (flush_in),
        .starve_hit (starve_hit),
        .grant      (grant)
    );

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [2:0] starve_q;

    assign starve_hit = (starve_q == STARVE_LIMIT);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            starve_q <= 3'd0;
        end else if (rdy_in && state_q == IDLE && |grant) begin
            if (grant[OWN_IF] || !if_req) begin
                starve_q <= 3'd0;
            end else if (!starve_hit) begin
                starve_q <= starve_q + 3'd1;
            end
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        mem_a    = '0;
        mem_wr   = 1'b0;
        mem_dout = '0;
        unique case (state_q)
            IDLE: begin
                if (grant[OWN_ST]) begin
                    state_d = WRITE;
                end else if (|grant) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (cnt_q < len_q) begin
                    mem_a = addr_cur;
                end
                if (flush_in || cnt_q >= len_q) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                mem_wr   = rdy_in;
                mem_a    = addr_cur;
                mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                if (cnt_q == len_q - 3'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            cnt_q   <= '0;
            len_q   <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            if_done <= 1'b0;
            if_data <= '0;
            ld_done <= 1'b0;
            ld_data <= '0;
            st_done <= 1'b0;
        end else if (rdy_in) begin
            state_q <= state_d;
            if_done <= 1'b0;
            ld_done <= 1'b0;
            st_done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cnt_q   <= '0;
                    rbuf_q  <= '0;
                    wdata_q <= st_data;
                    unique case (1'b1)
                        grant[OWN_ST]: begin
                            owner_q <= OWN_ST;
                            base_q  <= st_addr;
                            len_q   <= st_len;
                        end
                        grant[OWN_LD]: begin
                            owner_q <= OWN_LD;
                            base_q  <= ld_addr;
                            len_q   <= ld_len;
                        end
                        grant[OWN_IF]: begin
                            owner_q <= OWN_IF;
                            base_q  <= if_addr;
                            len_q   <= LEN_W;
                        end
                        default: ;
                    endcase
                end
                READ: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q != 3'd0) begin
                        rbuf_q <= rmerge;
                    end
                    if (flush_in) begin
                        cnt_q <= '0;
                    end else if (cnt_q >= len_q) begin
                        cnt_q <= '0;
                        if (owner_q == OWN_IF) begin
                            if_done <= 1'b1;
                            if_data <= rmerge;
                        end else begin
                            ld_done <= 1'b1;
                            ld_data <= rmerge;
                        end
                    end
                end
                WRITE: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (state_d == IDLE) begin
                        cnt_q   <= '0;
                        st_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 1-cycle RAM.
// Covers fetch, store/load order, I/O stall, flush, rdy, reset, starve.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        flush_in;
    logic        io_buffer_full;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [2:0]  ld_len;
    logic        ld_done;
    logic [31:0] ld_data;
    logic        st_req;
    logic [31:0] st_addr;
    logic [2:0]  st_len;
    logic [31:0] st_data;
    logic        st_done;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic [7:0] ram [0:1023];
    int tests = 0;
    int fails = 0;

    mem_arbiter dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .rdy_in         (rdy_in),
        .flush_in       (flush_in),
        .io_buffer_full (io_buffer_full),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .ld_req         (ld_req),
        .ld_addr        (ld_addr),
        .ld_len         (ld_len),
        .ld_done        (ld_done),
        .ld_data        (ld_data),
        .st_req         (st_req),
        .st_addr        (st_addr),
        .st_len         (st_len),
        .st_data        (st_data),
        .st_done        (st_done),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[9:0]];
        if (mem_wr) ram[mem_a[9:0]] = mem_dout;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic test_reset;
        step(3);
        tests++;
        if ({if_done, ld_done, st_done, mem_wr, mem_a, mem_dout,
             if_data, ld_data} !== '0) begin
            fails++;
            $display("FAIL reset: outputs not zero a=%h wr=%b",
                     mem_a, mem_wr);
        end
        rst_n_in = 1'b1;
        step(1);
    endtask

    task automatic test_fetch;
        if_addr = 32'h100;
        if_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            tests++;
            if (mem_a !== 32'h100 + i || mem_wr !== 1'b0) begin
                fails++;
                $display("FAIL fetch_addr%0d: a=%h wr=%b want a=%h wr=0",
                         i, mem_a, mem_wr, 32'h100 + i);
            end
        end
        step(1);
        tests++;
        if (if_done !== 1'b0) begin
            fails++;
            $display("FAIL fetch_early: if_done=%b want 0", if_done);
        end
        step(1);
        tests++;
        if (if_done !== 1'b1 || if_data !== 32'h93000013) begin
            fails++;
            $display("FAIL fetch_done: done=%b data=%h want 1 93000013",
                     if_done, if_data);
        end
        if_req = 1'b0;
        step(1);
    endtask

    task automatic test_store_ld;
        logic [7:0] eb [4];
        eb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        st_addr = 32'h20;
        st_len  = 3'd4;
        st_data = 32'hDEADBEEF;
        st_req  = 1'b1;
        ld_addr = 32'h102;
        ld_len  = 3'd2;
        ld_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            tests++;
            if (mem_wr !== 1'b1 || mem_a !== 32'h20 + i ||
                mem_dout !== eb[i]) begin
                fails++;
                $display("FAIL st_byte%0d: wr=%b a=%h d=%h want 1 %h %h",
                         i, mem_wr, mem_a, mem_dout, 32'h20 + i, eb[i]);
            end
        end
        step(1);
        tests++;
        if (st_done !== 1'b1 || ld_done !== 1'b0) begin
            fails++;
            $display("FAIL st_done: st=%b ld=%b want 1 0", st_done, ld_done);
        end
        st_req = 1'b0;
        step(1);
        tests++;
        if (mem_a !== 32'h102 || mem_wr !== 1'b0) begin
            fails++;
            $display("FAIL ld_after_st: a=%h wr=%b want 102 0", mem_a, mem_wr);
        end
        step(3);
        tests++;
        if (ld_done !== 1'b1 || ld_data !== 32'h00009300) begin
            fails++;
            $display("FAIL ld_done: done=%b data=%h want 1 00009300",
                     ld_done, ld_data);
        end
        ld_req = 1'b0;
        tests++;
        if ({ram[10'h23], ram[10'h22], ram[10'h21], ram[10'h20]}
            !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL st_ram: got %h want deadbeef",
                     {ram[10'h23], ram[10'h22], ram[10'h21], ram[10'h20]});
        end
        step(1);
    endtask

    task automatic test_io_stall;
        io_buffer_full = 1'b1;
        st_addr = 32'h30000;
        st_len  = 3'd1;
        st_data = 32'h55;
        st_req  = 1'b1;
        if_addr = 32'h100;
        if_req  = 1'b1;
        step(1);
        tests++;
        if (mem_a !== 32'h100 || mem_wr !== 1'b0) begin
            fails++;
            $display("FAIL io_if_first: a=%h wr=%b want 100 0", mem_a, mem_wr);
        end
        step(5);
        tests++;
        if (if_done !== 1'b1 || st_done !== 1'b0) begin
            fails++;
            $display("FAIL io_if_done: if=%b st=%b want 1 0", if_done, st_done);
        end
        if_req = 1'b0;
        step(1);
        tests++;
        if (mem_wr !== 1'b0 || mem_a !== 32'h0) begin
            fails++;
            $display("FAIL io_stalled: wr=%b a=%h want 0 0", mem_wr, mem_a);
        end
        io_buffer_full = 1'b0;
        step(1);
        tests++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_dout !== 8'h55) begin
            fails++;
            $display("FAIL io_write: wr=%b a=%h d=%h want 1 30000 55",
                     mem_wr, mem_a, mem_dout);
        end
        step(1);
        tests++;
        if (st_done !== 1'b1) begin
            fails++;
            $display("FAIL io_st_done: st_done=%b want 1", st_done);
        end
        st_req = 1'b0;
        step(1);
    endtask

    task automatic test_flush;
        int seen;
        ld_addr = 32'h100;
        ld_len  = 3'd2;
        ld_req  = 1'b1;
        step(2);
        tests++;
        if (mem_a !== 32'h101) begin
            fails++;
            $display("FAIL flush_cnt1: a=%h want 101", mem_a);
        end
        flush_in = 1'b1;
        ld_req   = 1'b0;
        step(1);
        flush_in = 1'b0;
        tests++;
        if (dut.state_q !== IDLE) begin
            fails++;
            $display("FAIL flush_idle: state=%0d want %0d", dut.state_q, IDLE);
        end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (ld_done) seen++;
            step(1);
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL flush_no_done: ld_done pulses=%0d want 0", seen);
        end
        st_addr = 32'h40;
        st_len  = 3'd2;
        st_data = 32'h1234;
        st_req  = 1'b1;
        step(1);
        flush_in = 1'b1;
        step(1);
        flush_in = 1'b0;
        tests++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h41 || mem_dout !== 8'h12) begin
            fails++;
            $display("FAIL flush_wr: wr=%b a=%h d=%h want 1 41 12",
                     mem_wr, mem_a, mem_dout);
        end
        step(1);
        tests++;
        if (st_done !== 1'b1) begin
            fails++;
            $display("FAIL flush_st_done: st_done=%b want 1", st_done);
        end
        st_req = 1'b0;
        step(1);
    endtask

    task automatic test_rdy_stall;
        if_addr = 32'h100;
        if_req  = 1'b1;
        step(3);
        tests++;
        if (mem_a !== 32'h102) begin
            fails++;
            $display("FAIL rdy_pre: a=%h want 102", mem_a);
        end
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            tests++;
            if (mem_a !== 32'h102 || mem_wr !== 1'b0 || if_done !== 1'b0) begin
                fails++;
                $display("FAIL rdy_hold%0d: a=%h wr=%b done=%b want 102 0 0",
                         i, mem_a, mem_wr, if_done);
            end
        end
        rdy_in = 1'b1;
        step(1);
        tests++;
        if (mem_a !== 32'h103) begin
            fails++;
            $display("FAIL rdy_resume: a=%h want 103", mem_a);
        end
        step(1);
        tests++;
        if (if_done !== 1'b0) begin
            fails++;
            $display("FAIL rdy_early: if_done=%b want 0", if_done);
        end
        step(1);
        tests++;
        if (if_done !== 1'b1 || if_data !== 32'h93000013) begin
            fails++;
            $display("FAIL rdy_done: done=%b data=%h want 1 93000013",
                     if_done, if_data);
        end
        if_req = 1'b0;
        step(1);
        st_addr = 32'h40;
        st_len  = 3'd2;
        st_data = 32'hA5C3;
        st_req  = 1'b1;
        step(1);
        rdy_in = 1'b0;
        #1;
        tests++;
        if (mem_wr !== 1'b0 || mem_a !== 32'h40) begin
            fails++;
            $display("FAIL rdy_wr_gate: wr=%b a=%h want 0 40", mem_wr, mem_a);
        end
        step(1);
        rdy_in = 1'b1;
        #1;
        tests++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h40 || mem_dout !== 8'hC3) begin
            fails++;
            $display("FAIL rdy_wr_hold: wr=%b a=%h d=%h want 1 40 c3",
                     mem_wr, mem_a, mem_dout);
        end
        step(2);
        tests++;
        if (st_done !== 1'b1 || ram[10'h41] !== 8'hA5) begin
            fails++;
            $display("FAIL rdy_wr_done: done=%b ram41=%h want 1 a5",
                     st_done, ram[10'h41]);
        end
        st_req = 1'b0;
        step(1);
    endtask

    task automatic test_reset_mid;
        st_addr = 32'h60;
        st_len  = 3'd4;
        st_data = 32'h11223344;
        st_req  = 1'b1;
        step(2);
        rst_n_in = 1'b0;
        #1;
        tests++;
        if ({mem_wr, mem_a, mem_dout, st_done} !== '0) begin
            fails++;
            $display("FAIL rst_mid_out: wr=%b a=%h d=%h want 0",
                     mem_wr, mem_a, mem_dout);
        end
        st_req = 1'b0;
        step(1);
        rst_n_in = 1'b1;
        step(2);
        tests++;
        if (st_done !== 1'b0 || ram[10'h60] !== 8'h44 ||
            ram[10'h61] !== 8'h00 || ram[10'h62] !== 8'hAA) begin
            fails++;
            $display("FAIL rst_mid_ram: done=%b %h %h %h want 0 44 00 aa",
                     st_done, ram[10'h60], ram[10'h61], ram[10'h62]);
        end
    endtask

    task automatic test_starve;
        int n;
        int got;
        logic [31:0] exp_a;
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_a = 32'h100;
`else
        exp_a = 32'h200;
`endif
        if_addr = 32'h100;
        if_req  = 1'b1;
        ld_addr = 32'h200;
        ld_len  = 3'd1;
        ld_req  = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (ld_done) n++;
        end
        tests++;
        if (n !== 4) begin
            fails++;
            $display("FAIL starve_ld_cnt: ld grants=%0d want 4", n);
        end
        step(1);
        tests++;
        if (mem_a !== exp_a) begin
            fails++;
            $display("FAIL starve_5th: a=%h want %h", mem_a, exp_a);
        end
        ld_req = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            step(1);
            if (if_done) got = 1;
        end
        tests++;
        if (got !== 1 || if_data !== 32'h93000013) begin
            fails++;
            $display("FAIL starve_if_done: seen=%0d data=%h want 1 93000013",
                     got, if_data);
        end
        if_req = 1'b0;
        step(2);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h13;
        ram[10'h101] = 8'h00;
        ram[10'h102] = 8'h00;
        ram[10'h103] = 8'h93;
        ram[10'h62]  = 8'hAA;
        rst_n_in       = 1'b0;
        rdy_in         = 1'b1;
        flush_in       = 1'b0;
        io_buffer_full = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        ld_req  = 1'b0;
        ld_addr = '0;
        ld_len  = 3'd1;
        st_req  = 1'b0;
        st_addr = '0;
        st_len  = 3'd1;
        st_data = '0;
        test_reset();
        test_fetch();
        test_store_ld();
        test_io_stall();
        test_flush();
        test_rdy_stall();
        test_reset_mid();
        test_starve();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
